// File: rtl/arbiter_pkg.sv
// +-------------------------------------------------------------------------+
// | arbiter_pkg : shared AER arbiter types and readout-controller defaults  |
// | rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
`default_nettype none

package arbiter_pkg;

    localparam int X_W   = 8;
    localparam int Y_W   = 8;
    localparam int TS_W  = 15;
    localparam int WIDTH = X_W + Y_W + TS_W + 1;

    typedef struct packed {
        logic [X_W-1:0]  x_add;
        logic [Y_W-1:0]  y_add;
        logic [TS_W-1:0] timestamp;
        logic            polarity;
    } event_t;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_RUN,
        RD_THROTTLE,
        RD_DRAIN
    } readout_state_t;

    localparam int RD_DEPTH_DEF        = 16;
    localparam int RD_AFULL_MARGIN_DEF = 2;

endpackage

`default_nettype wire

// File: rtl/aer_readout_ctrl_if.sv
// +-------------------------------------------------------------------------+
// | aer_readout_ctrl_if : arbiter-side and link-side handshake bundle       |
// | rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
`default_nettype none

interface aer_readout_ctrl_if;
    import arbiter_pkg::*;

    logic             arb_enable_o;
    logic             evt_valid_i;
    logic [WIDTH-1:0] evt_data_i;
    logic [WIDTH-1:0] m_data_o;
    logic             m_valid_o;
    logic             m_ready_i;

    modport slave (
        input  evt_valid_i,
        input  evt_data_i,
        input  m_ready_i,
        output arb_enable_o,
        output m_data_o,
        output m_valid_o
    );

    modport master (
        output evt_valid_i,
        output evt_data_i,
        output m_ready_i,
        input  arb_enable_o,
        input  m_data_o,
        input  m_valid_o
    );

endinterface

`default_nettype wire

// File: rtl/aer_sync_fifo.sv
// +-------------------------------------------------------------------------+
// | aer_sync_fifo : single-clock FIFO with registered head word, no policy  |
// | rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
`default_nettype none

module aer_sync_fifo #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  wire logic             clk_i,
    input  wire logic             reset_i,
    input  wire logic             push_i,
    input  wire logic [WIDTH-1:0] data_i,
    input  wire logic             pop_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [AW:0]           level_o,
    output logic [WIDTH-1:0]      head_o
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic [WIDTH-1:0] r_head;

    logic             w_do_pop;
    logic             w_do_push;
    logic [AW-1:0]    w_rd_next;

    assign full_o    = (r_level == (AW+1)'(DEPTH));
    assign empty_o   = (r_level == '0);
    assign level_o   = r_level;
    assign head_o    = r_head;

    // A full FIFO may still accept a word when the head leaves in the same cycle.
    assign w_do_pop  = pop_i & ~empty_o;
    assign w_do_push = push_i & (~full_o | w_do_pop);
    assign w_rd_next = r_rd_ptr + 1'b1;

    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_head   <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= w_rd_next;
            end
            if (w_do_push && !w_do_pop) begin
                r_level <= r_level + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_level <= r_level - 1'b1;
            end
            // Head always mirrors the entry at the post-edge read pointer.
            if (w_do_pop) begin
                if (r_level > (AW+1)'(1)) begin
                    r_head <= r_mem[w_rd_next];
                end else if (w_do_push) begin
                    r_head <= data_i;
                end
            end else if (empty_o && w_do_push) begin
                r_head <= data_i;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/aer_readout_ctrl.sv
// +-------------------------------------------------------------------------+
// | aer_readout_ctrl : gates the AER arbiter, buffers events, drains to link|
// | Optional macro AER_DROP_CNT_EN adds the saturating drop_cnt_o counter.  |
// | rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
`default_nettype none

module aer_readout_ctrl
    import arbiter_pkg::*;
#(
    parameter  int DEPTH        = RD_DEPTH_DEF,
    parameter  int AFULL_MARGIN = RD_AFULL_MARGIN_DEF,
    parameter  int RESUME_LEVEL = DEPTH / 2,
    localparam int LW           = $clog2(DEPTH) + 1
) (
    input  wire logic         clk_i,
    input  wire logic         reset_i,
    input  wire logic         run_i,
    aer_readout_ctrl_if.slave bus,
    output logic [LW-1:0]     level_o,
    output logic              overflow_o,
    output logic              busy_o
`ifdef AER_DROP_CNT_EN
    ,
    output logic [15:0]       drop_cnt_o
`endif
);

    localparam logic [1:0]    c_st_idle     = RD_IDLE;
    localparam logic [1:0]    c_st_run      = RD_RUN;
    localparam logic [1:0]    c_st_throttle = RD_THROTTLE;
    localparam logic [1:0]    c_st_drain    = RD_DRAIN;

    localparam logic [LW-1:0] c_afull_lvl   = LW'(DEPTH - AFULL_MARGIN);
    localparam logic [LW-1:0] c_resume_lvl  = LW'(RESUME_LEVEL);

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic          r_overflow;

    logic          w_full;
    logic          w_empty;
    logic [LW-1:0] w_level;
    logic          w_pop;
    logic          w_drop;
    logic          w_clear;

    aer_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (bus.evt_valid_i),
        .data_i  (bus.evt_data_i),
        .pop_i   (w_pop),
        .full_o  (w_full),
        .empty_o (w_empty),
        .level_o (w_level),
        .head_o  (bus.m_data_o)
    );

    assign w_pop            = ~w_empty & bus.m_ready_i;
    assign w_drop           = bus.evt_valid_i & w_full & ~w_pop;
    assign w_clear          = (r_state == c_st_idle) & run_i;

    assign bus.m_valid_o    = ~w_empty;
    assign bus.arb_enable_o = (r_state == c_st_run);
    assign busy_o           = (r_state != c_st_idle);
    assign level_o          = w_level;
    assign overflow_o       = r_overflow;

    // Dropping run_i always wins over the throttle/resume thresholds.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (run_i) w_state_nxt = c_st_run;
            end
            c_st_run: begin
                if (!run_i)                     w_state_nxt = c_st_drain;
                else if (w_level >= c_afull_lvl) w_state_nxt = c_st_throttle;
            end
            c_st_throttle: begin
                if (!run_i)                      w_state_nxt = c_st_drain;
                else if (w_level <= c_resume_lvl) w_state_nxt = c_st_run;
            end
            c_st_drain: begin
                if (w_empty && !bus.evt_valid_i) w_state_nxt = c_st_idle;
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state    <= c_st_idle;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_clear) begin
                r_overflow <= w_drop;
            end else if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

`ifdef AER_DROP_CNT_EN
    logic [15:0] r_drop_cnt;

    assign drop_cnt_o = r_drop_cnt;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_drop_cnt <= '0;
        end else if (w_clear) begin
            r_drop_cnt <= {15'd0, w_drop};
        end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_aer_readout_ctrl.sv
// +-------------------------------------------------------------------------+
// | tb_aer_readout_ctrl : directed + random bench with queue-based model    |
// | rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_aer_readout_ctrl;
    import arbiter_pkg::*;

    localparam int DEPTH  = 16;
    localparam int MARGIN = 2;
    localparam int RESUME = 8;

    localparam int M_OFF    = 0;
    localparam int M_ACTIVE = 1;
    localparam int M_HOLD   = 2;
    localparam int M_FLUSH  = 3;

    logic       clk     = 1'b0;
    logic       reset_i = 1'b0;
    logic       run_i   = 1'b0;
    logic [4:0] level_o;
    logic       overflow_o;
    logic       busy_o;
`ifdef AER_DROP_CNT_EN
    logic [15:0] drop_cnt_o;
`endif

    aer_readout_ctrl_if bus ();

    aer_readout_ctrl #(
        .DEPTH        (DEPTH),
        .AFULL_MARGIN (MARGIN),
        .RESUME_LEVEL (RESUME)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .run_i      (run_i),
        .bus        (bus),
        .level_o    (level_o),
        .overflow_o (overflow_o),
        .busy_o     (busy_o)
`ifdef AER_DROP_CNT_EN
        ,
        .drop_cnt_o (drop_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int               n_tests = 0;
    int               n_fail  = 0;

    logic [WIDTH-1:0] q[$];
    int               mode;
    bit               m_ovf;
    int               m_drops;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".level"},  64'(level_o),          64'(q.size()));
        chk({tag, ".valid"},  64'(bus.m_valid_o),    64'(q.size() != 0));
        chk({tag, ".enable"}, 64'(bus.arb_enable_o), 64'(mode == M_ACTIVE));
        chk({tag, ".busy"},   64'(busy_o),           64'(mode != M_OFF));
        chk({tag, ".ovf"},    64'(overflow_o),       64'(m_ovf));
        if (q.size() != 0) chk({tag, ".data"}, 64'(bus.m_data_o), 64'(q[0]));
`ifdef AER_DROP_CNT_EN
        chk({tag, ".drops"},  64'(drop_cnt_o),       64'(m_drops));
`endif
    endtask

    // One clock: drive inputs, advance the reference, then compare after the edge.
    task automatic step(input string tag, input logic run, input logic ev,
                        input logic [WIDTH-1:0] d, input logic rdy);
        int sz;
        bit pop, full, acc, drop;
        run_i           = run;
        bus.evt_valid_i = ev;
        bus.evt_data_i  = d;
        bus.m_ready_i   = rdy;
        sz   = q.size();
        pop  = (sz > 0) && rdy;
        full = (sz == DEPTH);
        acc  = ev && (!full || pop);
        drop = ev && full && !pop;
        case (mode)
            M_OFF:    if (run) begin mode = M_ACTIVE; m_ovf = 1'b0; m_drops = 0; end
            M_ACTIVE: if (!run) mode = M_FLUSH; else if (sz >= DEPTH - MARGIN) mode = M_HOLD;
            M_HOLD:   if (!run) mode = M_FLUSH; else if (sz <= RESUME) mode = M_ACTIVE;
            default:  if (sz == 0 && !ev) mode = M_OFF;
        endcase
        if (pop) void'(q.pop_front());
        if (acc) q.push_back(d);
        if (drop) begin
            m_ovf = 1'b1;
            if (m_drops < 65535) m_drops++;
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        reset_i = 1'b0;
        #1;
        q.delete();
        mode    = M_OFF;
        m_ovf   = 1'b0;
        m_drops = 0;
        chk({tag, ".async_level"}, 64'(level_o), 64'd0);
        @(posedge clk);
        #1;
        check_all(tag);
        chk({tag, ".data_zero"}, 64'(bus.m_data_o), 64'd0);
        reset_i = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [4:0] prev_lvl;
        logic [WIDTH-1:0] w;
        bus.evt_valid_i = 1'b0;
        bus.evt_data_i  = '0;
        bus.m_ready_i   = 1'b0;
        #2;
        do_reset("reset0");

        // Single event through the pipe.
        step("arm", 1, 0, '0, 1);
        chk("arm.en_before_evt", 64'(bus.arb_enable_o), 64'd1);
        step("evt", 1, 1, WIDTH'('h1A5), 1);
        chk("evt.valid", 64'(bus.m_valid_o), 64'd1);
        chk("evt.data",  64'(bus.m_data_o),  64'h1A5);
        step("pop", 1, 0, '0, 1);
        chk("pop.level", 64'(level_o), 64'd0);

        // Fill with the link stalled until the arbiter is gated off.
        n = 0;
        while (mode == M_ACTIVE && n < 40) begin
            step("fill", 1, 1, WIDTH'($urandom), 0);
            n++;
        end
        chk("throttle.level", 64'(level_o), 64'd15);
        chk("throttle.en",    64'(bus.arb_enable_o), 64'd0);
        step("inflight", 1, 1, WIDTH'($urandom), 0);
        chk("inflight.level", 64'(level_o), 64'd16);
        chk("inflight.ovf",   64'(overflow_o), 64'd0);

        // Release the link; enable returns after the level reaches the resume point.
        n = 0;
        prev_lvl = level_o;
        while (mode == M_HOLD && n < 40) begin
            prev_lvl = level_o;
            step("resume", 1, 0, '0, 1);
            n++;
        end
        chk("resume.prev_level", 64'(prev_lvl), 64'd8);
        chk("resume.en",         64'(bus.arb_enable_o), 64'd1);

        // Refill to full, then one event with no pop is dropped.
        n = 0;
        while (q.size() < DEPTH && n < 40) begin
            step("refill", 1, 1, WIDTH'($urandom), 0);
            n++;
        end
        chk("full.level", 64'(level_o), 64'd16);
        step("drop", 1, 1, WIDTH'($urandom), 0);
        chk("drop.ovf",   64'(overflow_o), 64'd1);
        chk("drop.level", 64'(level_o), 64'd16);
`ifdef AER_DROP_CNT_EN
        chk("drop.cnt",   64'(drop_cnt_o), 64'd1);
`endif
        step("sticky", 1, 0, '0, 0);
        chk("sticky.ovf", 64'(overflow_o), 64'd1);

        // Full with simultaneous push and pop.
        step("pushpop", 1, 1, WIDTH'($urandom), 1);
        chk("pushpop.level", 64'(level_o), 64'd16);
`ifdef AER_DROP_CNT_EN
        chk("pushpop.cnt",   64'(drop_cnt_o), 64'd1);
`endif

        // Drain three words after run_i falls.
        n = 0;
        while (q.size() > 3 && n < 40) begin
            step("unload", 1, 0, '0, 1);
            n++;
        end
        step("stop", 0, 0, '0, 0);
        chk("stop.en",   64'(bus.arb_enable_o), 64'd0);
        chk("stop.busy", 64'(busy_o), 64'd1);
        for (int i = 0; i < 3; i++) begin
            w = q[0];
            chk("drain.word", 64'(bus.m_data_o), 64'(w));
            step("drain", 0, 0, '0, 1);
        end
        chk("drain.level", 64'(level_o), 64'd0);
        step("idle", 0, 0, '0, 0);
        chk("idle.busy", 64'(busy_o), 64'd0);
        chk("idle.ovf",  64'(overflow_o), 64'd1);
        step("rerun", 1, 0, '0, 0);
        chk("rerun.ovf", 64'(overflow_o), 64'd0);

        // Randomized traffic with shifting link and run behaviour.
        for (int i = 0; i < 400; i++) begin
            int rdy_pct;
            rdy_pct = ((i / 50) % 2 == 0) ? 20 : 80;
            step("rand",
                 ($urandom_range(0, 19) != 0),
                 ($urandom_range(0, 99) < 70),
                 WIDTH'($urandom),
                 ($urandom_range(0, 99) < rdy_pct));
        end

        // Reset mid-run with five buffered words.
        do_reset("reset1");
        step("mr_arm", 1, 0, '0, 0);
        for (int i = 0; i < 5; i++) step("mr_fill", 1, 1, WIDTH'($urandom), 0);
        chk("mr.level_before", 64'(level_o), 64'd5);
        do_reset("reset2");
        chk("mr.en",    64'(bus.arb_enable_o), 64'd0);
        chk("mr.valid", 64'(bus.m_valid_o), 64'd0);
        chk("mr.busy",  64'(busy_o), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
